// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT address generator: FSM state encoding and
// default transform geometry.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

    localparam int NTT_LOGN_DEF       = 8;
    localparam int NTT_PIPE_DEPTH_DEF = 4;

endpackage

// File: rtl/ntt_addr_gen.sv
// Forward-NTT butterfly address generator. Walks LOGN stages of N/2
// butterflies each, presenting (addr_a, addr_b = addr_a + len, tw_idx) under
// ready/valid, and idles PIPE_DEPTH cycles between stages so the previous
// stage's write-backs land before the next stage reads them.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOGN       = NTT_LOGN_DEF,
    parameter int PIPE_DEPTH = NTT_PIPE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     issue_valid,
    output logic [LOGN-1:0]          addr_a,
    output logic [LOGN-1:0]          addr_b,
    output logic [LOGN-1:0]          tw_idx,
    output logic [$clog2(LOGN)-1:0]  stage
);

    localparam int N    = 1 << LOGN;
    localparam int HALF = N / 2;
    localparam int GW   = LOGN + 1;                  // group base can reach N
    localparam int CW   = LOGN - 1;                  // butterflies per stage counter
    localparam int STW  = $clog2(LOGN);
    localparam int DW   = $clog2(PIPE_DEPTH + 1);

    localparam logic [CW-1:0]  CNT_LAST   = CW'(HALF - 1);
    localparam logic [STW-1:0] STAGE_LAST = STW'(LOGN - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(PIPE_DEPTH - 1);

    ntt_state_e      state_q, state_d;
    logic [STW-1:0]  stage_q, stage_d;
    logic [LOGN-1:0] len_q, len_d;
    logic [GW-1:0]   grp_base_q, grp_base_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [LOGN-1:0] k_q, k_d;                       // wraps N -> 0 after the final fire
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            issue_valid_q, issue_valid_d;
    logic [LOGN-1:0] addr_b_q, addr_b_d;
    logic [GW-1:0]   grp_next;

    // Next-state and counter update for the issue/drain sequencer.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        len_d         = len_q;
        grp_base_d    = grp_base_q;
        j_d           = j_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        drain_d       = drain_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        issue_valid_d = issue_valid_q;
        grp_next      = grp_base_q + {len_q, 1'b0};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_ISSUE;
                    stage_d       = '0;
                    len_d         = LOGN'(HALF);
                    grp_base_d    = '0;
                    j_d           = '0;
                    k_d           = LOGN'(1);
                    cnt_d         = '0;
                    drain_d       = '0;
                    busy_d        = 1'b1;
                    issue_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Nothing moves unless the downstream takes this pair.
                if (ready) begin
                    k_d = k_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d       = ST_DRAIN;
                        len_d         = len_q >> 1;
                        grp_base_d    = '0;
                        j_d           = '0;
                        k_d           = k_q + LOGN'(1);
                        cnt_d         = '0;
                        drain_d       = '0;
                        issue_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (({1'b0, j_q} + GW'(1)) < (grp_base_q + {1'b0, len_q})) begin
                            j_d = j_q + LOGN'(1);
                        end else begin
                            grp_base_d = grp_next;
                            j_d        = grp_next[LOGN-1:0];
                            k_d        = k_q + LOGN'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Fixed-length bubble, deliberately blind to ready.
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ST_ISSUE;
                        stage_d       = stage_q + STW'(1);
                        issue_valid_d = 1'b1;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        addr_b_d = j_d + len_d;
    end

    // State, counter and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            len_q         <= '0;
            grp_base_q    <= '0;
            j_q           <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            addr_b_q      <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            len_q         <= len_d;
            grp_base_q    <= grp_base_d;
            j_q           <= j_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            issue_valid_q <= issue_valid_d;
            addr_b_q      <= addr_b_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign issue_valid = issue_valid_q;
    assign addr_a      = j_q;
    assign addr_b      = addr_b_q;
    assign tw_idx      = k_q;
    assign stage       = stage_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: a LOGN=3 instance for exact-sequence, stall, start
// and reset scenarios, and a LOGN=8 instance under random back-pressure.
module tb_ntt_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LOGN=3 instance
    logic       rst3, start3, ready3;
    logic       busy3, done3, iv3;
    logic [2:0] a3, b3, tw3;
    logic [1:0] st3;

    // LOGN=8 instance
    logic       rst8, start8, ready8;
    logic       busy8, done8, iv8;
    logic [7:0] a8, b8, tw8;
    logic [2:0] st8;

    ntt_addr_gen #(.LOGN(3), .PIPE_DEPTH(4)) dut3 (
        .clk(clk), .reset(rst3), .start(start3), .ready(ready3),
        .busy(busy3), .done(done3), .issue_valid(iv3),
        .addr_a(a3), .addr_b(b3), .tw_idx(tw3), .stage(st3)
    );

    ntt_addr_gen #(.LOGN(8), .PIPE_DEPTH(4)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .ready(ready8),
        .busy(busy8), .done(done8), .issue_valid(iv8),
        .addr_a(a8), .addr_b(b8), .tw_idx(tw8), .stage(st8)
    );

    typedef struct {
        int a;
        int b;
        int k;
        int s;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference pass: textbook Cooley-Tukey loop nest, one twiddle per group.
    task automatic build_expected(input int logn);
        int n, len, k;
        exp_t e;
        n = 1 << logn;
        k = 1;
        sb.delete();
        for (int s = 0; s < logn; s++) begin
            len = n >> (s + 1);
            for (int base = 0; base < n; base += 2 * len) begin
                for (int j = base; j < base + len; j++) begin
                    e.a = j; e.b = j + len; e.k = k; e.s = s;
                    sb.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic zero_chk3(input string pre);
        chk({pre, "_busy"},  busy3, 0);
        chk({pre, "_done"},  done3, 0);
        chk({pre, "_valid"}, iv3,   0);
        chk({pre, "_a"},     a3,    0);
        chk({pre, "_b"},     b3,    0);
        chk({pre, "_tw"},    tw3,   0);
        chk({pre, "_stage"}, st3,   0);
    endtask

    // One LOGN=3 pass; start at rel 0 plus optional extra start pulses,
    // optional ready stall window, optional one-cycle reset at rst_at.
    task automatic run3(input string name, input int stall_lo, input int stall_hi,
                        input int sp0, input int sp1, input int sp2,
                        input int rst_at, input int exp_done, input int max_cyc);
        int   done_cnt;
        logic busy_exp;
        exp_t e;
        done_cnt = 0;
        for (int rel = 0; rel <= max_cyc; rel++) begin
            @(posedge clk);
            #1;
            start3 = (rel == 0) || (rel == sp0) || (rel == sp1) || (rel == sp2);
            ready3 = !(rel >= stall_lo && rel <= stall_hi);
            rst3   = (rel == rst_at);
            @(negedge clk);
            busy_exp = (rel >= 1) && ((rst_at < 0) ? (rel <= exp_done) : (rel <= rst_at));
            chk({name, "_busy"}, busy3, busy_exp);
            if (rst_at >= 0 && rel == rst_at + 1) zero_chk3({name, "_rst"});
            if (iv3) begin
                if (sb.size() == 0) begin
                    chk({name, "_extra_issue"}, 1, 0);
                end else begin
                    e = sb[0];
                    chk({name, "_a"},     a3,  e.a);
                    chk({name, "_b"},     b3,  e.b);
                    chk({name, "_tw"},    tw3, e.k);
                    chk({name, "_stage"}, st3, e.s);
                    if (ready3) void'(sb.pop_front());
                end
            end
            if (done3) begin
                done_cnt++;
                chk({name, "_done_cyc"}, rel, exp_done);
            end
        end
        start3 = 1'b0;
        ready3 = 1'b1;
        rst3   = 1'b0;
        chk({name, "_done_cnt"}, done_cnt, (exp_done >= 0) ? 1 : 0);
        if (rst_at < 0) begin
            chk({name, "_sb_left"},    sb.size(), 0);
            chk({name, "_stage_hold"}, st3, 2);
        end
        sb.delete();
    endtask

    initial begin
        int fires, done_cnt;
        exp_t e;

        rst3 = 1'b1; start3 = 1'b0; ready3 = 1'b1;
        rst8 = 1'b1; start8 = 1'b0; ready8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_chk3("por");
        chk("por8_busy",  busy8, 0);
        chk("por8_valid", iv8,   0);
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        rst8 = 1'b0;

        build_expected(3);
        run3("basic", -1, -2, -1, -1, -1, -1, 25, 29);

        build_expected(3);
        run3("stall", 2, 4, -1, -1, -1, -1, 28, 32);

        build_expected(3);
        run3("restart", -1, -2, 2, 6, 25, -1, 25, 30);

        build_expected(3);
        run3("midrst", -1, -2, -1, -1, -1, 10, -1, 20);

        build_expected(3);
        run3("again", -1, -2, -1, -1, -1, -1, 25, 29);

        // LOGN=8 full pass under random back-pressure.
        build_expected(8);
        fires    = 0;
        done_cnt = 0;
        for (int rel = 0; rel < 6000; rel++) begin
            @(posedge clk);
            #1;
            start8 = (rel == 0);
            ready8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (iv8 && ready8) begin
                fires++;
                if (sb.size() == 0) begin
                    chk("big_extra_issue", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("big_a",     a8,  e.a);
                    chk("big_b",     b8,  e.b);
                    chk("big_tw",    tw8, e.k);
                    chk("big_stage", st8, e.s);
                end
            end
            if (done8) begin
                done_cnt++;
                chk("big_busy_at_done", busy8, 1);
            end
            if (done_cnt > 0 && !busy8) break;
        end
        start8 = 1'b0;
        chk("big_fires",    fires,     1024);
        chk("big_done_cnt", done_cnt,  1);
        chk("big_sb_left",  sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter LOGN, default 8, meaning log2 of transform size N = 2^LOGN (LOGN >= 2).
REQ-002 SHALL have parameter PIPE_DEPTH, default 4, meaning butterfly pipeline latency in cycles (>= 1).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a full forward NTT pass.
REQ-006 SHALL have port ready  input  1  downstream (coefficient memory/butterfly) accepts an issue this cycle.
REQ-007 SHALL have port busy  output  1  high from first cycle after an accepted start until the done cycle, inclusive.
REQ-008 SHALL have port done  output  1  single-cycle pulse when the last stage has fully drained.
REQ-009 SHALL have port issue_valid  output  1  butterfly operand pair presented; intended as input to the downstream valid delay line.
REQ-010 SHALL have port addr_a  output  LOGN  upper-operand coefficient address.
REQ-011 SHALL have port addr_b  output  LOGN  lower-operand address, always addr_a + len.
REQ-012 SHALL have port tw_idx  output  LOGN  twiddle ROM index.
REQ-013 SHALL have port stage  output  $clog2(LOGN)  current stage number, 0..LOGN-1.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: start=1 -> ISSUE next cycle; stage=0, len=N/2, grp_base=0, j=0, k=1, cnt=0.
REQ-016 ISSUE: issue_valid=1; addr_a=j, addr_b=j+len, tw_idx=k.
REQ-017 Issue fires only on issue_valid && ready; ready=0 SHALL hold all outputs and counters unchanged.
REQ-018 On fire, in-group: j+1 < grp_base+len -> j=j+1.
REQ-019 On fire, group end: grp_base += 2*len, j = new grp_base, k = k+1.
REQ-020 On fire with cnt == N/2-1 (stage end) -> DRAIN; len halves, grp_base=0, j=0; k still increments; cnt clears.
REQ-021 DRAIN: issue_valid=0; hold exactly PIPE_DEPTH cycles, independent of ready, so the previous stage's writes land before reads of the next stage.
REQ-022 DRAIN exit: stage < LOGN-1 -> stage+1, ISSUE; stage == LOGN-1 -> DONE.
REQ-023 DONE: done=1 and busy=1 for one cycle, then IDLE; addr/tw_idx/stage hold last values until the next start.
REQ-024 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-025 k SHALL span 1..N-1 across the pass with no wrap; after last fire k = N, truncated to 0 on tw_idx (never presented as valid).
REQ-026 With ready held 1, start at cycle t: issue cycles t+1..t+N/2, done at cycle t+1+LOGN*(N/2+PIPE_DEPTH).

Reset
REQ-027 reset SHALL force IDLE at any state, including mid-pass, with no done pulse.
REQ-028 After reset: busy=0, done=0, issue_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, all internal counters 0.

Structure
REQ-029 Shared package ntt_pkg SHALL hold the FSM state enum and default LOGN/PIPE_DEPTH constants.
REQ-030 Single flat module, no sub-module; the valid/address delay line matching PIPE_DEPTH sits outside this block.

Verification
REQ-031 LOGN=3, PIPE_DEPTH=4, ready=1, start at t=0 -> (a,b,k): stage0 (0,4,1)(1,5,1)(2,6,1)(3,7,1); stage1 (0,2,2)(1,3,2)(4,6,3)(5,7,3); stage2 (0,1,4)(2,3,5)(4,5,6)(6,7,7); done at t=25.
REQ-032 Same, ready=0 on cycles 2-4 -> outputs frozen at (1,5,1) during the stall, sequence unchanged, done at t=28.
REQ-033 start pulsed during ISSUE, during DRAIN, and on the done cycle -> no restart; exactly one done per accepted start.
REQ-034 reset asserted mid-stage1 -> next cycle all outputs 0, IDLE; fresh start reproduces the REQ-031 sequence.
REQ-035 LOGN=8, ready random 50% -> 1024 fires total, all addr_b = addr_a + len, tw_idx 1..255 monotonic, exactly one done.
